// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry fetch-to-decode instruction FIFO with valid/ready handshakes and single-cycle flush
module if_id_queue #(
    parameter int                INST_W = 32,
    parameter int                ADDR_W = 32,
    parameter int                INT_W  = 8,
    parameter int                DEPTH  = 4,
    parameter logic [INST_W-1:0] NOP    = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       inst_valid_i,
    output logic                       inst_ready_o,
    input  logic [INST_W-1:0]          inst_i,
    input  logic [ADDR_W-1:0]          inst_addr_i,
    input  logic [INT_W-1:0]           int_flag_i,
    output logic                       inst_valid_o,
    input  logic                       id_ready_i,
    output logic [INST_W-1:0]          inst_o,
    output logic [ADDR_W-1:0]          inst_addr_o,
    output logic [INT_W-1:0]           int_flag_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [INST_W-1:0] inst_q [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [INT_W-1:0]  flag_q [DEPTH];
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              enq, deq;

    // ready depends only on the registered count, never on id_ready_i
    assign inst_ready_o = cnt_q != CW'(DEPTH);
    assign inst_valid_o = cnt_q != '0;
    assign count_o      = cnt_q;
    assign enq          = inst_valid_i && inst_ready_o && !flush_i;
    assign deq          = inst_valid_o && id_ready_i && !flush_i;

    assign inst_o      = inst_valid_o ? inst_q[rd_q] : NOP;
    assign inst_addr_o = inst_valid_o ? addr_q[rd_q] : '0;
    assign int_flag_o  = inst_valid_o ? flag_q[rd_q] : '0;

    always_comb begin
        wr_d  = flush_i ? '0 : wr_q + PW'(enq);
        rd_d  = flush_i ? '0 : rd_q + PW'(deq);
        cnt_d = flush_i ? '0 : cnt_q + CW'(enq) - CW'(deq);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // storage is never cleared; empty outputs are masked instead
    always_ff @(posedge clk) begin
        if (enq) begin
            inst_q[wr_q] <= inst_i;
            addr_q[wr_q] <= inst_addr_i;
            flag_q[wr_q] <= int_flag_i;
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: table-driven directed check of if_id_queue plus interrupt-tag and async-reset sequences
module tb_if_id_queue;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] TAG = 32'hA0000000;

    logic        clk = 0, rst = 1;
    logic        flush_i = 0, inst_valid_i = 0, id_ready_i = 0;
    logic [31:0] inst_i = 0, inst_addr_i = 0;
    logic [7:0]  int_flag_i = 0;
    logic        inst_ready_o, inst_valid_o;
    logic [31:0] inst_o, inst_addr_o;
    logic [7:0]  int_flag_o;
    logic [2:0]  count_o;
    int          nvec = 0, nerr = 0;

    if_id_queue dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i), .int_flag_i(int_flag_i),
        .inst_valid_o(inst_valid_o), .id_ready_i(id_ready_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o), .int_flag_o(int_flag_o),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl, vi, rdy;
        logic [31:0] a;
        logic        ev, er;
        logic [31:0] ea;
        logic [2:0]  ec;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic fl, logic vi, logic rdy, logic [31:0] a,
                                logic ev, logic er, logic [31:0] ea, logic [2:0] ec);
        vec_t v;
        v.fl = fl; v.vi = vi; v.rdy = rdy; v.a = a;
        v.ev = ev; v.er = er; v.ea = ea; v.ec = ec;
        return v;
    endfunction

    task automatic check(string nm, logic ev, logic er, logic [31:0] ei,
                         logic [31:0] ea, logic [7:0] ef, logic [2:0] ec);
        nvec++;
        if ({inst_valid_o, inst_ready_o, inst_o, inst_addr_o, int_flag_o, count_o}
            !== {ev, er, ei, ea, ef, ec}) begin
            nerr++;
            $display("FAIL %s: got v=%b r=%b inst=%h addr=%h flag=%h cnt=%0d, want v=%b r=%b inst=%h addr=%h flag=%h cnt=%0d",
                     nm, inst_valid_o, inst_ready_o, inst_o, inst_addr_o, int_flag_o, count_o,
                     ev, er, ei, ea, ef, ec);
        end
    endtask

    initial begin
        // idle and fill with decode stalled
        tv.push_back(mk(0, 0, 0, 32'h0,   0, 1, 32'h0, 0));
        tv.push_back(mk(0, 1, 0, 32'h0,   1, 1, 32'h0, 1));
        tv.push_back(mk(0, 1, 0, 32'h4,   1, 1, 32'h0, 2));
        tv.push_back(mk(0, 1, 0, 32'h8,   1, 1, 32'h0, 3));
        tv.push_back(mk(0, 1, 0, 32'hC,   1, 0, 32'h0, 4));
        tv.push_back(mk(0, 1, 0, 32'h10,  1, 0, 32'h0, 4));
        // drain in order, then a pop on empty is ignored
        tv.push_back(mk(0, 0, 1, 32'h0,   1, 1, 32'h4, 3));
        tv.push_back(mk(0, 0, 1, 32'h0,   1, 1, 32'h8, 2));
        tv.push_back(mk(0, 0, 1, 32'h0,   1, 1, 32'hC, 1));
        tv.push_back(mk(0, 0, 1, 32'h0,   0, 1, 32'h0, 0));
        tv.push_back(mk(0, 0, 1, 32'h0,   0, 1, 32'h0, 0));
        // streaming at count 2 across pointer wraps
        tv.push_back(mk(0, 1, 0, 32'h100, 1, 1, 32'h100, 1));
        tv.push_back(mk(0, 1, 0, 32'h104, 1, 1, 32'h100, 2));
        for (int i = 0; i < 8; i++)
            tv.push_back(mk(0, 1, 1, 32'h108 + 4*i, 1, 1, 32'h104 + 4*i, 2));
        tv.push_back(mk(0, 0, 1, 32'h0,   1, 1, 32'h124, 1));
        tv.push_back(mk(0, 0, 1, 32'h0,   0, 1, 32'h0, 0));
        // flush with a push of 0x200 in the same cycle
        tv.push_back(mk(0, 1, 0, 32'h1F0, 1, 1, 32'h1F0, 1));
        tv.push_back(mk(0, 1, 0, 32'h1F4, 1, 1, 32'h1F0, 2));
        tv.push_back(mk(0, 1, 0, 32'h1F8, 1, 1, 32'h1F0, 3));
        tv.push_back(mk(1, 1, 1, 32'h200, 0, 1, 32'h0, 0));
        tv.push_back(mk(0, 1, 0, 32'h300, 1, 1, 32'h300, 1));
        tv.push_back(mk(0, 0, 1, 32'h0,   0, 1, 32'h0, 0));

        #12;
        check("in_reset", 0, 1, NOP, 0, 0, 0);
        @(negedge clk);
        rst = 0;
        check("after_reset", 0, 1, NOP, 0, 0, 0);

        foreach (tv[k]) begin
            flush_i      = tv[k].fl;
            inst_valid_i = tv[k].vi;
            id_ready_i   = tv[k].rdy;
            inst_addr_i  = tv[k].a;
            inst_i       = TAG | tv[k].a;
            int_flag_i   = 0;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", k), tv[k].ev, tv[k].er,
                  tv[k].ev ? (TAG | tv[k].ea) : NOP, tv[k].ev ? tv[k].ea : 32'h0, 8'h0, tv[k].ec);
        end

        // interrupt flag travels with its instruction
        flush_i = 0; id_ready_i = 0; inst_valid_i = 1;
        inst_i = 32'h00100073; inst_addr_i = 32'h40; int_flag_i = 8'h01;
        @(posedge clk);
        #1;
        check("int_tag", 1, 1, 32'h00100073, 32'h40, 8'h01, 1);
        inst_i = 32'h00000093; inst_addr_i = 32'h44; int_flag_i = 8'h00;
        @(posedge clk);
        #1;
        check("int_hold", 1, 1, 32'h00100073, 32'h40, 8'h01, 2);
        inst_valid_i = 0;
        // reset asserted mid-cycle takes effect before the next edge
        #2 rst = 1;
        #1;
        check("async_rst", 0, 1, NOP, 0, 0, 0);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        check("post_rst_idle", 0, 1, NOP, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
